result_writer_5: RTL and testbench
==================================

Name: result_writer_5

Overview:
- Collects a stream of narrow calculation results, one per `calc_done_i` pulse.
- Packs every 5 consecutive results into one DWIDTH-bit word.
- Writes each packed word to port B of a true-dual-port result BRAM at incrementing addresses.
- Sits between the compute core's result output and the result memory that the host later reads back.

Parameters:
- DWIDTH, 40: BRAM word width; must equal 5*IWIDTH.
- AWIDTH, 2: BRAM address width.
- MEM_SIZE, 2: number of BRAM words used; write address range 0..MEM_SIZE-1.
- IWIDTH, 8: width of one calculation result.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- calc_done_i, input, 1: result-valid strobe; one result accepted per high cycle.
- calc_result_i, input, IWIDTH: result value; sampled when calc_done_i=1.
- q_b_i, input, DWIDTH: BRAM port-B read data; unused, kept for interface compatibility.
- addr_b_o, output, AWIDTH: BRAM port-B address.
- ce_b_o, output, 1: BRAM port-B chip enable.
- we_b_o, output, 1: BRAM port-B write enable.
- d_b_o, output, DWIDTH: BRAM port-B write data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - addr_b_o, ce_b_o, we_b_o and d_b_o are all 0.
  - Slot counter, packing register and word pointer are 0.
  - A partially packed group is discarded.
- Packing:
  - Slot counter cnt runs 0..4.
  - On each rising edge with calc_done_i=1, calc_result_i goes into pack[cnt*IWIDTH +: IWIDTH]. The first result of a group lands in bits [IWIDTH-1:0]; the fifth lands in the MSBs.
  - cnt increments, and wraps 4->0 on the fifth sample.
  - Cycles with calc_done_i=0 change nothing; gaps of any length between strobes are allowed.
- Write (all outputs registered):
  - On the edge that accepts the fifth result, the registers load:
    - d_b_o = complete word, i.e. the four stored results plus the current calc_result_i in the top slot;
    - addr_b_o = current word pointer;
    - ce_b_o = 1 and we_b_o = 1.
  - Write latency: ce_b_o/we_b_o are high in the cycle right after the 5th strobe edge, for exactly one cycle.
  - The next edge clears ce_b_o and we_b_o to 0 unless another word completes on that edge.
  - addr_b_o and d_b_o hold their last values while idle.
  - The word pointer increments after each write and wraps MEM_SIZE-1 -> 0, so old data is overwritten.
  - Back-to-back strobes are allowed. A strobe in the write cycle is accepted into slot 0 of the next group; the pack register is cleared for the new group.
- No read path: ce_b_o is never asserted with we_b_o=0.
- Arithmetic: no arithmetic on the data; pure bit concatenation. calc_result_i is taken as unsigned IWIDTH bits.

Test Plan:
- Reset: hold reset_n=0 for 10 ns mid-idle -> addr_b_o=0, ce_b_o=0, we_b_o=0, d_b_o=0 immediately, without waiting for a clock edge.
- Group 0: single-cycle strobes with 31, 179, 125, 11, 1, each followed by 4 idle cycles -> one cycle after the 5th strobe: ce_b_o=we_b_o=1, addr_b_o=0, d_b_o=40'h010B7DB31F; no write pulse during the first four strobes.
- Group 1: strobes with 3, 69, 101, 225, 131 -> single write pulse with addr_b_o=1, d_b_o=40'h83E1654503; afterwards ce_b_o/we_b_o=0 and d_b_o holds that value.
- Wrap-around: a third group 1, 2, 3, 4, 5 -> write at addr_b_o=0 with d_b_o=40'h0504030201.
- Back-to-back: ten consecutive strobes 0x10..0x19 with no gaps:
  - write at addr 0, data 40'h1413121110;
  - write at addr 1, data 40'h1918171615, exactly 5 cycles after the first write;
  - no sample lost.
- Reset mid-group: 3 strobes, pulse reset_n low, then 5 strobes A1..A5 -> single write at addr 0 with data 40'hA5A4A3A2A1; the pre-reset samples are not present.

Source files
------------

// File: rtl/result_writer_5_if.sv
// rtl/result_writer_5_if.sv - result stream in / BRAM port-B out bundle for result_writer_5
interface result_writer_5_if #(
  parameter int DWIDTH = 40,
  parameter int AWIDTH = 2,
  parameter int IWIDTH = 8
);
  logic              calc_done_i;
  logic [IWIDTH-1:0] calc_result_i;
  logic [DWIDTH-1:0] q_b_i;
  logic [AWIDTH-1:0] addr_b_o;
  logic              ce_b_o;
  logic              we_b_o;
  logic [DWIDTH-1:0] d_b_o;

  modport master (
    output calc_done_i, calc_result_i, q_b_i,
    input  addr_b_o, ce_b_o, we_b_o, d_b_o
  );

  modport slave (
    input  calc_done_i, calc_result_i, q_b_i,
    output addr_b_o, ce_b_o, we_b_o, d_b_o
  );
endinterface

// File: rtl/result_writer_5.sv
// rtl/result_writer_5.sv - packs five narrow results per word and writes them to BRAM port B
module result_writer_5 #(
  parameter int DWIDTH   = 40,
  parameter int AWIDTH   = 2,
  parameter int MEM_SIZE = 2,
  parameter int IWIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  result_writer_5_if.slave bus
);
  localparam int SLOTS  = 5;
  localparam int PWIDTH = (SLOTS - 1) * IWIDTH;

  logic [2:0]        r_cnt;
  logic [PWIDTH-1:0] r_pack;
  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_addr;
  logic              r_ce;
  logic              r_we;
  logic [DWIDTH-1:0] r_d;

  logic              w_last;
  logic [PWIDTH-1:0] w_pack_next;
  logic [DWIDTH-1:0] w_word;
  logic [AWIDTH-1:0] w_wptr_next;
  logic              w_unused_q_b;

  assign w_unused_q_b = ^bus.q_b_i;

  // Only the first four results are stored; the fifth goes straight into the top slot of the word.
  always_comb begin
    w_last      = bus.calc_done_i && (r_cnt == 3'(SLOTS - 1));
    w_pack_next = r_pack;
    for (int s = 0; s < SLOTS - 1; s++) begin
      if (r_cnt == 3'(s)) begin
        w_pack_next[s*IWIDTH +: IWIDTH] = bus.calc_result_i;
      end
    end
    w_word      = {bus.calc_result_i, r_pack};
    w_wptr_next = (r_wptr == AWIDTH'(MEM_SIZE - 1)) ? '0 : r_wptr + AWIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_pack <= '0;
      r_wptr <= '0;
      r_addr <= '0;
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
      r_d    <= '0;
    end else begin
      r_ce <= 1'b0;
      r_we <= 1'b0;
      if (w_last) begin
        r_d    <= w_word;
        r_addr <= r_wptr;
        r_ce   <= 1'b1;
        r_we   <= 1'b1;
        r_cnt  <= '0;
        r_pack <= '0;
        r_wptr <= w_wptr_next;
      end else if (bus.calc_done_i) begin
        r_pack <= w_pack_next;
        r_cnt  <= r_cnt + 3'd1;
      end
    end
  end

  assign bus.addr_b_o = r_addr;
  assign bus.ce_b_o   = r_ce;
  assign bus.we_b_o   = r_we;
  assign bus.d_b_o    = r_d;
endmodule

// File: tb/tb_result_writer_5.sv
// tb/tb_result_writer_5.sv - directed self-checking bench for result_writer_5
module tb_result_writer_5;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  result_writer_5_if #(.DWIDTH(40), .AWIDTH(2), .IWIDTH(8)) bus ();

  result_writer_5 #(.DWIDTH(40), .AWIDTH(2), .MEM_SIZE(2), .IWIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    bus.calc_done_i   = 1'b1;
    bus.calc_result_i = v;
    @(negedge clk);
    bus.calc_done_i   = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.addr_b_o !== 2'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.addr_b_o); end
    n_cmp++; if (bus.ce_b_o !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b want 0", bus.ce_b_o); end
    n_cmp++; if (bus.we_b_o !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.we_b_o); end
    n_cmp++; if (bus.d_b_o !== 40'h0) begin n_err++; $display("FAIL reset_d: got %h want 0", bus.d_b_o); end
    #9 reset_n = 1'b1;
  endtask

  task automatic test_group0;
    logic [7:0] v [5];
    v = '{8'd31, 8'd179, 8'd125, 8'd11, 8'd1};
    for (int i = 0; i < 5; i++) begin
      strobe(v[i]);
      if (i < 4) begin
        n_cmp++; if (bus.ce_b_o !== 1'b0 || bus.we_b_o !== 1'b0) begin n_err++; $display("FAIL g0_early_write[%0d]: got ce=%b we=%b want 0", i, bus.ce_b_o, bus.we_b_o); end
        repeat (4) @(negedge clk);
      end
    end
    n_cmp++; if (bus.ce_b_o !== 1'b1 || bus.we_b_o !== 1'b1) begin n_err++; $display("FAIL g0_pulse: got ce=%b we=%b want 1", bus.ce_b_o, bus.we_b_o); end
    n_cmp++; if (bus.addr_b_o !== 2'd0) begin n_err++; $display("FAIL g0_addr: got %h want 0", bus.addr_b_o); end
    n_cmp++; if (bus.d_b_o !== 40'h010B7DB31F) begin n_err++; $display("FAIL g0_data: got %h want 010b7db31f", bus.d_b_o); end
    @(negedge clk);
    n_cmp++; if (bus.ce_b_o !== 1'b0 || bus.we_b_o !== 1'b0) begin n_err++; $display("FAIL g0_pulse_end: got ce=%b we=%b want 0", bus.ce_b_o, bus.we_b_o); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_group1;
    logic [7:0] v [5];
    v = '{8'd3, 8'd69, 8'd101, 8'd225, 8'd131};
    for (int i = 0; i < 5; i++) begin
      strobe(v[i]);
      if (i < 4) begin
        n_cmp++; if (bus.ce_b_o !== 1'b0) begin n_err++; $display("FAIL g1_early_write[%0d]: got %b want 0", i, bus.ce_b_o); end
      end
    end
    n_cmp++; if (bus.ce_b_o !== 1'b1 || bus.we_b_o !== 1'b1) begin n_err++; $display("FAIL g1_pulse: got ce=%b we=%b want 1", bus.ce_b_o, bus.we_b_o); end
    n_cmp++; if (bus.addr_b_o !== 2'd1) begin n_err++; $display("FAIL g1_addr: got %h want 1", bus.addr_b_o); end
    n_cmp++; if (bus.d_b_o !== 40'h83E1654503) begin n_err++; $display("FAIL g1_data: got %h want 83e1654503", bus.d_b_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ce_b_o !== 1'b0 || bus.we_b_o !== 1'b0) begin n_err++; $display("FAIL g1_idle: got ce=%b we=%b want 0", bus.ce_b_o, bus.we_b_o); end
    n_cmp++; if (bus.d_b_o !== 40'h83E1654503 || bus.addr_b_o !== 2'd1) begin n_err++; $display("FAIL g1_hold: got %h@%h want 83e1654503@1", bus.d_b_o, bus.addr_b_o); end
  endtask

  task automatic test_wrap;
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    n_cmp++; if (bus.ce_b_o !== 1'b1 || bus.we_b_o !== 1'b1) begin n_err++; $display("FAIL wrap_pulse: got ce=%b we=%b want 1", bus.ce_b_o, bus.we_b_o); end
    n_cmp++; if (bus.addr_b_o !== 2'd0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", bus.addr_b_o); end
    n_cmp++; if (bus.d_b_o !== 40'h0504030201) begin n_err++; $display("FAIL wrap_data: got %h want 0504030201", bus.d_b_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.d_b_o !== 40'h0 || bus.addr_b_o !== 2'd0) begin n_err++; $display("FAIL b2b_async_reset: got %h@%h want 0@0", bus.d_b_o, bus.addr_b_o); end
    #4 reset_n = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 5) begin
        n_cmp++; if (bus.ce_b_o !== 1'b1 || bus.addr_b_o !== 2'd0 || bus.d_b_o !== 40'h1413121110) begin n_err++; $display("FAIL b2b_write0: got ce=%b %h@%h want 1 1413121110@0", bus.ce_b_o, bus.d_b_o, bus.addr_b_o); end
      end else if (k == 10) begin
        n_cmp++; if (bus.ce_b_o !== 1'b1 || bus.addr_b_o !== 2'd1 || bus.d_b_o !== 40'h1918171615) begin n_err++; $display("FAIL b2b_write1: got ce=%b %h@%h want 1 1918171615@1", bus.ce_b_o, bus.d_b_o, bus.addr_b_o); end
      end else begin
        n_cmp++; if (bus.ce_b_o !== 1'b0 || bus.we_b_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: got ce=%b we=%b want 0", k, bus.ce_b_o, bus.we_b_o); end
      end
      if (k < 10) begin
        bus.calc_done_i   = 1'b1;
        bus.calc_result_i = 8'h10 + 8'(k);
      end else begin
        bus.calc_done_i   = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_group;
    logic [7:0] v [5];
    v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    strobe(8'h55);
    strobe(8'h66);
    strobe(8'h77);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.d_b_o !== 40'h0) begin n_err++; $display("FAIL mid_reset_d: got %h want 0", bus.d_b_o); end
    #4 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(v[i]);
      if (i < 4) begin
        n_cmp++; if (bus.ce_b_o !== 1'b0) begin n_err++; $display("FAIL mid_early_write[%0d]: got %b want 0", i, bus.ce_b_o); end
      end
    end
    n_cmp++; if (bus.ce_b_o !== 1'b1 || bus.we_b_o !== 1'b1) begin n_err++; $display("FAIL mid_pulse: got ce=%b we=%b want 1", bus.ce_b_o, bus.we_b_o); end
    n_cmp++; if (bus.addr_b_o !== 2'd0) begin n_err++; $display("FAIL mid_addr: got %h want 0", bus.addr_b_o); end
    n_cmp++; if (bus.d_b_o !== 40'hA5A4A3A2A1) begin n_err++; $display("FAIL mid_data: got %h want a5a4a3a2a1", bus.d_b_o); end
    @(negedge clk);
    n_cmp++; if (bus.ce_b_o !== 1'b0) begin n_err++; $display("FAIL mid_pulse_end: got %b want 0", bus.ce_b_o); end
  endtask

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    reset_n           = 1'b1;
    bus.calc_done_i   = 1'b0;
    bus.calc_result_i = 8'h00;
    bus.q_b_i         = 40'h0;
    test_reset;
    test_group0;
    test_group1;
    test_wrap;
    test_back_to_back;
    test_reset_mid_group;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
